// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest CSR-state channel.
package difftest_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned NUM_CSR     = 17;
    localparam int unsigned COREID_W    = 8;
    localparam int unsigned PRIV_W      = 2;
    localparam int unsigned HDR_SEQ_W   = 16;
    localparam int unsigned BEAT_IDX_W  = 5;
    localparam int unsigned DROP_W      = 16;

    localparam logic [15:0] HDR_MAGIC        = 16'hC5A7;
    localparam logic [7:0]  BEAT_TOTAL_PLAIN = 8'd18;
    localparam logic [7:0]  BEAT_TOTAL_CSUM  = 8'd19;

    // Beat index within a snapshot stream; CSR beats follow the port order.
    typedef enum logic [BEAT_IDX_W-1:0] {
        CSR_HDR      = 5'd0,
        CSR_MSTATUS  = 5'd1,
        CSR_SSTATUS  = 5'd2,
        CSR_MEPC     = 5'd3,
        CSR_SEPC     = 5'd4,
        CSR_MTVAL    = 5'd5,
        CSR_STVAL    = 5'd6,
        CSR_MTVEC    = 5'd7,
        CSR_STVEC    = 5'd8,
        CSR_MCAUSE   = 5'd9,
        CSR_SCAUSE   = 5'd10,
        CSR_SATP     = 5'd11,
        CSR_MIP      = 5'd12,
        CSR_MIE      = 5'd13,
        CSR_MSCRATCH = 5'd14,
        CSR_SSCRATCH = 5'd15,
        CSR_MIDELEG  = 5'd16,
        CSR_MEDELEG  = 5'd17,
        CSR_CSUM     = 5'd18
    } csr_idx_e;

    // One captured commit snapshot; csr[0] is mstatus, csr[16] is medeleg.
    typedef struct packed {
        logic [COREID_W-1:0]             coreid;
        logic [PRIV_W-1:0]               priv;
        logic [HDR_SEQ_W-1:0]            seq;
        logic [NUM_CSR-1:0][XLEN-1:0]    csr;
    } snap_t;

    // Header beat layout: magic, pad, beat count, sequence, pad, privilege, hart id.
    function automatic logic [XLEN-1:0] make_header(
        input logic [COREID_W-1:0]  coreid,
        input logic [PRIV_W-1:0]    priv,
        input logic [HDR_SEQ_W-1:0] seq,
        input logic [7:0]           total
    );
        return {HDR_MAGIC, 8'h00, total, seq, 6'h00, priv, coreid};
    endfunction

endpackage

// File: rtl/difftest_snap_fifo.sv
// Snapshot FIFO between core capture and beat serializer; full/empty/count are registered.
module difftest_snap_fifo
    import difftest_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
)(
    input  logic  io_clock,
    input  logic  io_reset,
    input  logic  push,
    input  snap_t wr_data,
    input  logic  pop,
    output snap_t rd_data,
    output logic  full,
    output logic  empty
);

    snap_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Snapshot storage; contents are don't-care until written.
    always_ff @(posedge io_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and registered status flags.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/difftest_csr_serializer.sv
// Difftest CSR-state source: buffers per-commit CSR snapshots and streams them as 64-bit beats.
// Build option: DIFFTEST_CSR_CHKSUM_EN appends an XOR checksum beat over header and CSR beats.
module difftest_csr_serializer
    import difftest_pkg::*;
#(
    parameter int unsigned SNAP_DEPTH = 2,
    parameter int unsigned SEQ_W      = 16
)(
    input  logic                io_clock,
    input  logic                io_reset,
    input  logic [COREID_W-1:0] io_coreid,
    input  logic                io_cap_valid,
    output logic                io_cap_ready,
    input  logic [PRIV_W-1:0]   io_priviledgeMode,
    input  logic [XLEN-1:0]     io_mstatus,
    input  logic [XLEN-1:0]     io_sstatus,
    input  logic [XLEN-1:0]     io_mepc,
    input  logic [XLEN-1:0]     io_sepc,
    input  logic [XLEN-1:0]     io_mtval,
    input  logic [XLEN-1:0]     io_stval,
    input  logic [XLEN-1:0]     io_mtvec,
    input  logic [XLEN-1:0]     io_stvec,
    input  logic [XLEN-1:0]     io_mcause,
    input  logic [XLEN-1:0]     io_scause,
    input  logic [XLEN-1:0]     io_satp,
    input  logic [XLEN-1:0]     io_mip,
    input  logic [XLEN-1:0]     io_mie,
    input  logic [XLEN-1:0]     io_mscratch,
    input  logic [XLEN-1:0]     io_sscratch,
    input  logic [XLEN-1:0]     io_mideleg,
    input  logic [XLEN-1:0]     io_medeleg,
    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic [XLEN-1:0]     io_out_data,
    output logic                io_out_last,
    output logic [DROP_W-1:0]   io_drop_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;
    localparam logic [1:0] ST_CSUM = 2'd3;

`ifdef DIFFTEST_CSR_CHKSUM_EN
    localparam logic [7:0] HDR_BEAT_TOTAL = BEAT_TOTAL_CSUM;
`else
    localparam logic [7:0] HDR_BEAT_TOTAL = BEAT_TOTAL_PLAIN;
`endif

    logic [1:0]            state_q;
    logic [1:0]            state_nxt;
    logic [BEAT_IDX_W-1:0] idx_q;
    logic [BEAT_IDX_W-1:0] idx_nxt;
    logic                  valid_nxt;
    logic [XLEN-1:0]       data_nxt;
    logic                  last_nxt;
    logic                  pop_c;
    logic                  beat_fire;
    logic [SEQ_W-1:0]      seq_q;
    logic                  cap_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    snap_t                 snap_in;
    snap_t                 head;
`ifdef DIFFTEST_CSR_CHKSUM_EN
    logic [XLEN-1:0]       csum_q;
    logic [XLEN-1:0]       csum_nxt;
`endif

    assign io_cap_ready = !fifo_full;
    assign cap_push     = io_cap_valid && io_cap_ready;
    assign beat_fire    = io_out_valid && io_out_ready;

    // Assemble the snapshot from the core's commit-time CSR view.
    always_comb begin
        snap_in.coreid  = io_coreid;
        snap_in.priv    = io_priviledgeMode;
        snap_in.seq     = HDR_SEQ_W'(seq_q);
        snap_in.csr[0]  = io_mstatus;
        snap_in.csr[1]  = io_sstatus;
        snap_in.csr[2]  = io_mepc;
        snap_in.csr[3]  = io_sepc;
        snap_in.csr[4]  = io_mtval;
        snap_in.csr[5]  = io_stval;
        snap_in.csr[6]  = io_mtvec;
        snap_in.csr[7]  = io_stvec;
        snap_in.csr[8]  = io_mcause;
        snap_in.csr[9]  = io_scause;
        snap_in.csr[10] = io_satp;
        snap_in.csr[11] = io_mip;
        snap_in.csr[12] = io_mie;
        snap_in.csr[13] = io_mscratch;
        snap_in.csr[14] = io_sscratch;
        snap_in.csr[15] = io_mideleg;
        snap_in.csr[16] = io_medeleg;
    end

    difftest_snap_fifo #(
        .DEPTH (SNAP_DEPTH)
    ) u_fifo (
        .io_clock (io_clock),
        .io_reset (io_reset),
        .push     (cap_push),
        .wr_data  (snap_in),
        .pop      (pop_c),
        .rd_data  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Beat sequencing: header, 17 CSR beats, optional checksum; outputs held until accepted.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        valid_nxt = io_out_valid;
        data_nxt  = io_out_data;
        last_nxt  = io_out_last;
        pop_c     = 1'b0;
`ifdef DIFFTEST_CSR_CHKSUM_EN
        csum_nxt  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_HDR;
                    idx_nxt   = BEAT_IDX_W'(CSR_HDR);
                    valid_nxt = 1'b1;
                    data_nxt  = make_header(head.coreid, head.priv, head.seq, HDR_BEAT_TOTAL);
                    last_nxt  = 1'b0;
`ifdef DIFFTEST_CSR_CHKSUM_EN
                    csum_nxt  = '0;
`endif
                end
            end
            ST_HDR: begin
                if (beat_fire) begin
                    state_nxt = ST_BODY;
                    idx_nxt   = BEAT_IDX_W'(CSR_MSTATUS);
                    data_nxt  = head.csr[0];
                    last_nxt  = 1'b0;
`ifdef DIFFTEST_CSR_CHKSUM_EN
                    csum_nxt  = csum_q ^ io_out_data;
`endif
                end
            end
            ST_BODY: begin
                if (beat_fire) begin
`ifdef DIFFTEST_CSR_CHKSUM_EN
                    csum_nxt = csum_q ^ io_out_data;
`endif
                    if (idx_q == BEAT_IDX_W'(CSR_MEDELEG)) begin
`ifdef DIFFTEST_CSR_CHKSUM_EN
                        state_nxt = ST_CSUM;
                        idx_nxt   = BEAT_IDX_W'(CSR_CSUM);
                        data_nxt  = csum_q ^ io_out_data;
                        last_nxt  = 1'b1;
`else
                        state_nxt = ST_IDLE;
                        idx_nxt   = BEAT_IDX_W'(CSR_HDR);
                        valid_nxt = 1'b0;
                        data_nxt  = '0;
                        last_nxt  = 1'b0;
                        pop_c     = 1'b1;
`endif
                    end else begin
                        // Beat k carries csr[k-1], so the next beat after idx_q is csr[idx_q].
                        idx_nxt  = idx_q + BEAT_IDX_W'(1);
                        data_nxt = head.csr[idx_q];
`ifdef DIFFTEST_CSR_CHKSUM_EN
                        last_nxt = 1'b0;
`else
                        last_nxt = (idx_q == BEAT_IDX_W'(CSR_MIDELEG));
`endif
                    end
                end
            end
            ST_CSUM: begin
                if (beat_fire) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = BEAT_IDX_W'(CSR_HDR);
                    valid_nxt = 1'b0;
                    data_nxt  = '0;
                    last_nxt  = 1'b0;
                    pop_c     = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
                data_nxt  = '0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state and registered beat outputs.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            io_out_valid <= 1'b0;
            io_out_data  <= '0;
            io_out_last  <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            idx_q        <= idx_nxt;
            io_out_valid <= valid_nxt;
            io_out_data  <= data_nxt;
            io_out_last  <= last_nxt;
        end
    end

`ifdef DIFFTEST_CSR_CHKSUM_EN
    // Running XOR of beats already sent for the current snapshot.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_nxt;
        end
    end
`endif

    // Sequence number per accepted capture and saturating overflow-drop counter.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            seq_q       <= '0;
            io_drop_cnt <= '0;
        end else begin
            if (cap_push) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (io_cap_valid && !io_cap_ready && (io_drop_cnt != {DROP_W{1'b1}})) begin
                io_drop_cnt <= io_drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_difftest_csr_serializer.sv
// Self-checking bench for difftest_csr_serializer with a queue-based stream model.
module tb_difftest_csr_serializer;

    localparam int DEPTH = 2;
`ifdef DIFFTEST_CSR_CHKSUM_EN
    localparam int NBEATS = 19;
    localparam bit CSUM   = 1'b1;
`else
    localparam int NBEATS = 18;
    localparam bit CSUM   = 1'b0;
`endif

    logic        io_clock = 1'b0;
    logic        io_reset = 1'b0;
    logic [7:0]  io_coreid = '0;
    logic        io_cap_valid = 1'b0;
    logic        io_cap_ready;
    logic [1:0]  io_priviledgeMode = '0;
    logic [63:0] csr_in [17];
    logic        io_out_valid;
    logic        io_out_ready = 1'b0;
    logic [63:0] io_out_data;
    logic        io_out_last;
    logic [15:0] io_drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [63:0] exp_data [$];
    bit          exp_last [$];
    int          occ = 0;
    logic [15:0] seq_m = '0;
    logic [15:0] drop_m = '0;
    int          idle_run = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    bit          fresh = 1'b0;
    bit          mon_en = 1'b0;
    logic [63:0] got_data [$];
    bit          got_last [$];

    always #5 io_clock = ~io_clock;

    difftest_csr_serializer #(.SNAP_DEPTH(DEPTH), .SEQ_W(16)) dut (
        .io_clock          (io_clock),
        .io_reset          (io_reset),
        .io_coreid         (io_coreid),
        .io_cap_valid      (io_cap_valid),
        .io_cap_ready      (io_cap_ready),
        .io_priviledgeMode (io_priviledgeMode),
        .io_mstatus        (csr_in[0]),
        .io_sstatus        (csr_in[1]),
        .io_mepc           (csr_in[2]),
        .io_sepc           (csr_in[3]),
        .io_mtval          (csr_in[4]),
        .io_stval          (csr_in[5]),
        .io_mtvec          (csr_in[6]),
        .io_stvec          (csr_in[7]),
        .io_mcause         (csr_in[8]),
        .io_scause         (csr_in[9]),
        .io_satp           (csr_in[10]),
        .io_mip            (csr_in[11]),
        .io_mie            (csr_in[12]),
        .io_mscratch       (csr_in[13]),
        .io_sscratch       (csr_in[14]),
        .io_mideleg        (csr_in[15]),
        .io_medeleg        (csr_in[16]),
        .io_out_valid      (io_out_valid),
        .io_out_ready      (io_out_ready),
        .io_out_data       (io_out_data),
        .io_out_last       (io_out_last),
        .io_drop_cnt       (io_drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    endtask

    // Expected beat list for one accepted snapshot, built straight from the stream format.
    task automatic model_push(input logic [7:0] cid, input logic [1:0] pr, input logic [15:0] sq);
        logic [63:0] b;
        logic [63:0] x;
        b = {16'hC5A7, 8'h00, 8'(NBEATS), sq, 6'h00, pr, cid};
        x = b;
        exp_data.push_back(b);
        exp_last.push_back(1'b0);
        for (int i = 0; i < 17; i++) begin
            exp_data.push_back(csr_in[i]);
            exp_last.push_back(!CSUM && (i == 16));
            x = x ^ csr_in[i];
        end
        if (CSUM) begin
            exp_data.push_back(x);
            exp_last.push_back(1'b1);
        end
    endtask

    // Compare process: outputs are stable at the falling edge for the coming rising edge.
    always @(negedge io_clock) begin
        if (mon_en && !io_reset) begin
            bit acc;
            bit q_empty_pre;
            acc = io_cap_valid && (occ < DEPTH);
            q_empty_pre = (exp_data.size() == 0) && !io_out_valid;
            check("cap_ready", 64'(io_cap_ready), 64'(occ < DEPTH));
            check("drop_cnt", 64'(io_drop_cnt), 64'(drop_m));
            if (fresh) begin
                check("hdr_not_before_n_plus_2", 64'(io_out_valid), 64'(0));
                fresh = 1'b0;
            end
            if (prev_stall) begin
                check("stall_valid", 64'(io_out_valid), 64'(1));
                check("stall_data", io_out_data, prev_data);
                check("stall_last", 64'(io_out_last), 64'(prev_last));
            end
            prev_stall = io_out_valid && !io_out_ready;
            prev_data  = io_out_data;
            prev_last  = io_out_last;
            if (!io_out_valid && exp_data.size() != 0) begin
                idle_run++;
                check("idle_bubble_le1", 64'(idle_run <= 1), 64'(1));
            end else begin
                idle_run = 0;
            end
            if (io_out_valid && io_out_ready) begin
                got_data.push_back(io_out_data);
                got_last.push_back(io_out_last);
                check("beat_expected", 64'(exp_data.size() != 0), 64'(1));
                if (exp_data.size() != 0) begin
                    check("beat_data", io_out_data, exp_data[0]);
                    check("beat_last", 64'(io_out_last), 64'(exp_last[0]));
                    if (exp_last[0]) occ--;
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                end
            end
            if (io_cap_valid) begin
                if (acc) begin
                    model_push(io_coreid, io_priviledgeMode, seq_m);
                    seq_m++;
                    occ++;
                    if (q_empty_pre) fresh = 1'b1;
                end else if (drop_m != 16'hFFFF) begin
                    drop_m++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge io_clock);
        #1;
    endtask

    task automatic do_reset();
        io_cap_valid = 1'b0;
        #2;
        io_reset = 1'b1;
        exp_data.delete();
        exp_last.delete();
        occ = 0; seq_m = '0; drop_m = '0; idle_run = 0;
        prev_stall = 1'b0; fresh = 1'b0;
        #1;
        check("rst_out_valid", 64'(io_out_valid), 64'(0));
        check("rst_out_data", io_out_data, 64'(0));
        check("rst_out_last", 64'(io_out_last), 64'(0));
        check("rst_cap_ready", 64'(io_cap_ready), 64'(1));
        check("rst_drop_cnt", 64'(io_drop_cnt), 64'(0));
        tick(2);
        io_reset = 1'b0;
        mon_en = 1'b1;
        tick(1);
    endtask

    task automatic capture(input logic [7:0] cid, input logic [1:0] pr);
        io_cap_valid = 1'b1;
        io_coreid = cid;
        io_priviledgeMode = pr;
        tick(1);
        io_cap_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((exp_data.size() != 0 || io_out_valid) && i < budget) begin
            tick(1);
            i++;
        end
        check("drain_in_budget", 64'(exp_data.size() == 0 && !io_out_valid), 64'(1));
    endtask

    task automatic wait_beats(input int n, input int budget);
        int i;
        i = 0;
        while (got_data.size() < n && i < budget) begin
            tick(1);
            i++;
        end
        check("beats_in_budget", 64'(got_data.size()), 64'(n));
    endtask

    task automatic rand_csrs();
        for (int i = 0; i < 17; i++) csr_in[i] = {$urandom, $urandom};
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        for (int i = 0; i < 17; i++) csr_in[i] = '0;
        do_reset();

        // Single capture, sink always ready
        rand_csrs();
        csr_in[0] = 64'hA_0000_1800;
        io_out_ready = 1'b1;
        got_data.delete(); got_last.delete();
        capture(8'd3, 2'd3);
        wait_drain(100);
        check("t1_beat_count", 64'(got_data.size()), 64'(NBEATS));
        if (got_data.size() == NBEATS) begin
`ifdef DIFFTEST_CSR_CHKSUM_EN
            check("t1_header", got_data[0], 64'hC5A7_0013_0000_0303);
            check("t1_last_beat18", 64'(got_last[18]), 64'(1));
`else
            check("t1_header", got_data[0], 64'hC5A7_0012_0000_0303);
`endif
            check("t1_mstatus", got_data[1], 64'hA_0000_1800);
            check("t1_last_beat17", 64'(got_last[17]), 64'(!CSUM));
            check("t1_last_beat16", 64'(got_last[16]), 64'(0));
        end

        // Sink stalls for 10 cycles while beat 5 is presented
        rand_csrs();
        got_data.delete(); got_last.delete();
        capture(8'h41, 2'd1);
        wait_beats(5, 50);
        io_out_ready = 1'b0;
        tick(10);
        check("t2_valid_held", 64'(io_out_valid), 64'(1));
        check("t2_beat5_data", io_out_data, csr_in[4]);
        io_out_ready = 1'b1;
        wait_drain(100);
        check("t2_beat_count", 64'(got_data.size()), 64'(NBEATS));

        // Three back-to-back captures into a two-entry buffer with a stalled sink
        do_reset();
        io_out_ready = 1'b0;
        got_data.delete(); got_last.delete();
        io_cap_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_csrs();
            io_coreid = 8'(i + 10);
            io_priviledgeMode = 2'(i);
            tick(1);
        end
        io_cap_valid = 1'b0;
        check("t3_cap_ready_full", 64'(io_cap_ready), 64'(0));
        check("t3_drop_one", 64'(io_drop_cnt), 64'(1));
        io_out_ready = 1'b1;
        wait_drain(200);
        check("t3_beat_count", 64'(got_data.size()), 64'(2 * NBEATS));
        if (got_data.size() == 2 * NBEATS) begin
            w = got_data[0];
            check("t3_seq0", 64'(w[31:16]), 64'(0));
            w = got_data[NBEATS];
            check("t3_seq1", 64'(w[31:16]), 64'(1));
        end

        // Reset while beat 9 is presented; next snapshot restarts at seq 0
        rand_csrs();
        got_data.delete(); got_last.delete();
        capture(8'h22, 2'd2);
        wait_beats(9, 50);
        do_reset();
        got_data.delete(); got_last.delete();
        rand_csrs();
        capture(8'd5, 2'd1);
        wait_drain(100);
        check("t4_beat_count", 64'(got_data.size()), 64'(NBEATS));
        if (got_data.size() == NBEATS) begin
`ifdef DIFFTEST_CSR_CHKSUM_EN
            check("t4_header", got_data[0], 64'hC5A7_0013_0000_0105);
`else
            check("t4_header", got_data[0], 64'hC5A7_0012_0000_0105);
`endif
        end

`ifdef DIFFTEST_CSR_CHKSUM_EN
        // All-zero snapshot: checksum equals the header
        do_reset();
        for (int i = 0; i < 17; i++) csr_in[i] = '0;
        got_data.delete(); got_last.delete();
        capture(8'd0, 2'd0);
        wait_drain(100);
        check("t5_beat_count", 64'(got_data.size()), 64'(19));
        if (got_data.size() == 19) begin
            check("t5_csum", got_data[18], 64'hC5A7_0013_0000_0000);
            check("t5_csum_last", 64'(got_last[18]), 64'(1));
            check("t5_medeleg_not_last", 64'(got_last[17]), 64'(0));
        end
`endif

        // Randomized traffic and backpressure
        for (int c = 0; c < 3000; c++) begin
            rand_csrs();
            io_coreid = 8'($urandom);
            io_priviledgeMode = 2'($urandom);
            io_cap_valid = ($urandom_range(0, 3) == 0);
            io_out_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        io_cap_valid = 1'b0;
        io_out_ready = 1'b1;
        wait_drain(200);

        // Drop counter saturation
        do_reset();
        io_out_ready = 1'b0;
        io_cap_valid = 1'b1;
        tick(2 + 65535 + 2);
        io_cap_valid = 1'b0;
        check("t7_drop_saturated", 64'(io_drop_cnt), 64'hFFFF);
        io_out_ready = 1'b1;
        wait_drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
